// File: rtl/pulse_width_encoder.sv
// pulse_width_encoder: turns one binary value per gamma cycle into a pulse-width temporal code.
// Define PULSE_CLIP_EN to truncate late pulses at the window end instead of saturating the onset.
module pulse_width_encoder #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int PULSE_WIDTH = 8,
   parameter int VALUE_W = $clog2(GAMMA_CYCLE_WIDTH)
) (
   input  logic               aclk,
   input  logic               grst,
   input  logic               in_valid,
   input  logic [VALUE_W-1:0] in_value,
   input  logic               in_null,
   output logic               in_ready,
   output logic               y,
   output logic               gstart
);
   localparam logic [VALUE_W-1:0] LAST = VALUE_W'(GAMMA_CYCLE_WIDTH - 1);
   logic [VALUE_W-1:0] phase_q, phase_d, pend_val_q, pend_val_d, act_val_q, act_val_d, load_val;
   logic pend_full_q, pend_full_d, pend_null_q, pend_null_d, act_on_q, act_on_d, y_q, y_d;
   logic wrap, xfer;
`ifdef PULSE_CLIP_EN
   assign load_val = pend_val_q;
`else
   localparam int SAT = GAMMA_CYCLE_WIDTH - PULSE_WIDTH;
   assign load_val = int'(pend_val_q) > SAT ? VALUE_W'(SAT) : pend_val_q;
`endif
   always_comb begin
      wrap        = phase_q == LAST;
      in_ready    = !grst || !pend_full_q || wrap;
      gstart      = !grst || phase_q == '0;
      xfer        = in_valid && in_ready;
      phase_d     = wrap ? '0 : phase_q + 1'b1;
      pend_full_d = xfer || (pend_full_q && !wrap);
      pend_val_d  = xfer ? in_value : pend_val_q;
      pend_null_d = xfer ? (in_null || int'(in_value) >= GAMMA_CYCLE_WIDTH) : pend_null_q;
      act_on_d    = wrap ? (pend_full_q && !pend_null_q) : act_on_q;
      act_val_d   = wrap ? load_val : act_val_q;
      // computed from next-state so y lines up with the phase register
      y_d         = act_on_d && phase_d >= act_val_d && int'(phase_d) < int'(act_val_d) + PULSE_WIDTH;
   end
   always_ff @(posedge aclk) begin
      if (!grst) begin
         phase_q     <= '0;
         pend_full_q <= 1'b0;
         pend_val_q  <= '0;
         pend_null_q <= 1'b0;
         act_on_q    <= 1'b0;
         act_val_q   <= '0;
         y_q         <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         pend_full_q <= pend_full_d;
         pend_val_q  <= pend_val_d;
         pend_null_q <= pend_null_d;
         act_on_q    <= act_on_d;
         act_val_q   <= act_val_d;
         y_q         <= y_d;
      end
   end
   assign y = y_q;
endmodule

// File: tb/tb_pulse_width_encoder.sv
// tb_pulse_width_encoder: randomized and directed bench against a window-schedule model.
module tb_pulse_width_encoder;
   localparam int G = 16, PW = 8, VW = $clog2(G);
   logic clk = 0, grst = 0, in_valid = 0, in_null = 0;
   logic [VW-1:0] in_value = '0;
   logic in_ready, y, gstart;
   int errors = 0, checks = 0, cyc = 0;
   bit started = 0;
   int sched[int];
   always #5 clk = ~clk;
   pulse_width_encoder #(.GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)) dut (
      .aclk(clk), .grst(grst), .in_valid(in_valid), .in_value(in_value),
      .in_null(in_null), .in_ready(in_ready), .y(y), .gstart(gstart));
   task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
      end
   endtask
   // the window whose value is scheduled next is exactly what the pending slot holds
   function automatic bit m_ready();
      return !sched.exists(cyc / G + 1) || cyc % G == G - 1;
   endfunction
   function automatic bit m_y();
      int w = cyc / G, p = cyc % G, v;
      if (!sched.exists(w) || sched[w] < 0) return 0;
      v = sched[w];
`ifndef PULSE_CLIP_EN
      if (v > G - PW) v = G - PW;
`endif
      return p >= v && p < v + PW;
   endfunction
   task automatic tick();
      @(posedge clk);
      if (!grst) begin
         cyc = 0;
         sched.delete();
         started = 1;
      end else begin
         if (in_valid && m_ready())
            sched[cyc / G + ((cyc % G == G - 1) ? 2 : 1)] = (in_null || int'(in_value) >= G) ? -1 : int'(in_value);
         cyc++;
      end
      #1;
   endtask
   always @(negedge clk) begin
      if (started) begin
         if (!grst) begin
            chk("ready_in_reset", in_ready, 1);
            chk("gstart_in_reset", gstart, 1);
         end else begin
            chk("y", y, m_y());
            chk("gstart", gstart, cyc % G == 0);
            chk("in_ready", in_ready, m_ready());
         end
      end
   end
   task automatic idle();
      in_valid = 0;
      tick();
   endtask
   task automatic idle_to(int p);
      for (int i = 0; i < 2 * G && cyc % G != p; i++) idle();
   endtask
   task automatic offer(int n, int vals[3], bit nuls[3], output logic [4*G-1:0] cap);
      int k = 0;
      bit acc;
      for (int i = 0; i < 4 * G; i++) begin
         cap[i] = y;
         in_valid = k < n;
         if (k < n) begin
            in_value = VW'(vals[k]);
            in_null = nuls[k];
         end
         acc = in_valid && m_ready();
         tick();
         if (acc) k++;
      end
      in_valid = 0;
      in_null = 0;
      chk("stream_accepted", k, n);
   endtask
   initial begin
      logic [4*G-1:0] cap;
      logic [G-1:0] win;
      grst = 0;
      tick();
      tick();
      grst = 1;
      chk("reset_y", y, 0);
      chk("reset_gstart", gstart, 1);
      chk("reset_ready", in_ready, 1);
      offer(0, '{0, 0, 0}, '{0, 0, 0}, cap);
      chk("idle_windows", cap, 0);
      idle_to(5);
      in_valid = 1;
      in_value = 2;
      in_null = 0;
      tick();
      in_valid = 0;
      chk("ready_low_ph6", in_ready, 0);
      idle_to(15);
      chk("ready_high_ph15", in_ready, 1);
      idle();
      for (int i = 0; i < G; i++) begin
         win[i] = y;
         idle();
      end
      chk("v2_window", win, 16'h03FC);
      offer(3, '{0, 3, 7}, '{0, 0, 0}, cap);
      chk("stream_w0", cap[15:0], 0);
      chk("stream_w1", cap[31:16], 16'h00FF);
      chk("stream_w2", cap[47:32], 16'h07F8);
      chk("stream_w3", cap[63:48], 16'h7F80);
      offer(1, '{12, 0, 0}, '{0, 0, 0}, cap);
`ifdef PULSE_CLIP_EN
      chk("late_v12", cap[31:16], 16'hF000);
`else
      chk("late_v12", cap[31:16], 16'hFF00);
`endif
      chk("late_after", cap[63:32], 0);
      offer(2, '{0, 4, 0}, '{1, 0, 0}, cap);
      chk("null_window", cap[31:16], 0);
      chk("wrap_accept_v4", cap[47:32], 16'h0FF0);
      chk("after_v4", cap[63:48], 0);
      in_valid = 1;
      in_value = 2;
      tick();
      in_valid = 0;
      idle_to(0);
      idle();
      in_valid = 1;
      in_value = 5;
      tick();
      in_valid = 0;
      chk("pending_full_ready", in_ready, 0);
      idle_to(6);
      chk("mid_pulse_y", y, 1);
      grst = 0;
      tick();
      chk("rst_mid_y", y, 0);
      chk("rst_mid_gstart", gstart, 1);
      grst = 1;
      chk("rst_mid_ready", in_ready, 1);
      offer(0, '{0, 0, 0}, '{0, 0, 0}, cap);
      chk("post_reset_silent", cap, 0);
      for (int i = 0; i < 3000; i++) begin
         grst = $urandom_range(0, 99) != 0;
         in_valid = $urandom_range(0, 1) == 1;
         in_value = VW'($urandom_range(0, G - 1));
         in_null = $urandom_range(0, 4) == 0;
         tick();
      end
      grst = 1;
      in_valid = 0;
      idle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
